// File: rtl/vga_palette_display.sv
// Two-stage VGA pixel colour pipeline: a writable palette lookup plus border,
// colour-bar and blink display modes, with rgb_valid aligned to rgb.
module vga_palette_display #(
    parameter int DATA_W  = 2,
    parameter int RGB_W   = 3,
    parameter int BORDER  = 10,
    parameter int H_START = 160,
    parameter int H_END   = 799,
    parameter int V_START = 41,
    parameter int V_END   = 520,
    parameter logic [RGB_W-1:0] BORDER_COLOR = RGB_W'(3'b111),
    parameter int BLINK_BIT = 5
) (
    input  logic              clk_25,
    input  logic              rst_n,
    input  logic [9:0]        h_count,
    input  logic [9:0]        v_count,
    input  logic              bright,
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        mode,
    input  logic              pal_we,
    input  logic [DATA_W-1:0] pal_addr,
    input  logic [RGB_W-1:0]  pal_wdata,
    output logic [RGB_W-1:0]  rgb,
    output logic              rgb_valid
);

    localparam int PAL_N = 1 << DATA_W;

    localparam logic [1:0] MODE_PAL    = 2'b00;
    localparam logic [1:0] MODE_BORDER = 2'b01;
    localparam logic [1:0] MODE_BARS   = 2'b10;
    localparam logic [1:0] MODE_BLINK  = 2'b11;

    function automatic logic [RGB_W-1:0] pal_default(input int idx);
        logic [RGB_W-1:0] c;
        c = '0;
        case (idx)
            0:       c[2:0] = 3'b111;
            1:       c[2:0] = 3'b011;
            2:       c[2:0] = 3'b101;
            3:       c[2:0] = 3'b001;
            default: c      = '0;
        endcase
        return c;
    endfunction

    logic [RGB_W-1:0]  pal_q [PAL_N];
    logic [5:0]        frame_q, frame_d;
    logic [DATA_W-1:0] data_q;
    logic              bright_q;
    logic [1:0]        mode_q;
    logic              border_q, border_d;
    logic [2:0]        bar_q;
    logic              blink_q;
    logic [RGB_W-1:0]  rgb_q, rgb_d;
    logic              valid_q, valid_d;
    logic [RGB_W-1:0]  pal_rd;
    logic [RGB_W-1:0]  bar_rgb;

    // Border flag from the raw counters, registered in stage 1.
    always_comb begin
        int h_int;
        int v_int;
        h_int    = int'(h_count);
        v_int    = int'(v_count);
        border_d = ((h_int >= H_START) && (h_int <= H_START + BORDER - 1)) ||
                   ((h_int >= H_END - BORDER + 1) && (h_int <= H_END)) ||
                   ((v_int >= V_START) && (v_int <= V_START + BORDER - 1)) ||
                   ((v_int >= V_END - BORDER + 1) && (v_int <= V_END));
    end

    // Frame counter advances on the frame-start pixel and wraps naturally.
    always_comb begin
        if ((h_count == 10'd0) && (v_count == 10'd0)) begin
            frame_d = frame_q + 6'd1;
        end else begin
            frame_d = frame_q;
        end
    end

    // Stage 1: capture the pixel and its per-pixel attributes.
    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            frame_q  <= 6'd0;
            data_q   <= '0;
            bright_q <= 1'b0;
            mode_q   <= 2'b00;
            border_q <= 1'b0;
            bar_q    <= 3'd0;
            blink_q  <= 1'b0;
        end else begin
            frame_q  <= frame_d;
            data_q   <= data;
            bright_q <= bright;
            mode_q   <= mode;
            border_q <= border_d;
            bar_q    <= h_count[9:7];
            blink_q  <= frame_q[BLINK_BIT];
        end
    end

    // Palette storage; reset takes priority over a concurrent write.
    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            for (int i = 0; i < PAL_N; i++) begin
                pal_q[i] <= pal_default(i);
            end
        end else if (pal_we) begin
            pal_q[pal_addr] <= pal_wdata;
        end
    end

    // Stage-2 colour selection; the palette read sees pre-write contents.
    always_comb begin
        pal_rd         = pal_q[data_q];
        bar_rgb        = '0;
        bar_rgb[2:0]   = bar_q;
        valid_d        = bright_q;
        rgb_d          = '0;
        if (!bright_q) begin
            rgb_d = '0;
        end else begin
            case (mode_q)
                MODE_PAL:    rgb_d = pal_rd;
                MODE_BORDER: rgb_d = border_q ? BORDER_COLOR : pal_rd;
                MODE_BARS:   rgb_d = bar_rgb;
                MODE_BLINK:  rgb_d = blink_q ? ~pal_rd : pal_rd;
                default:     rgb_d = '0;
            endcase
        end
    end

    // Stage 2: registered outputs.
    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            rgb_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            valid_q <= valid_d;
        end
    end

    assign rgb       = rgb_q;
    assign rgb_valid = valid_q;

endmodule

// File: tb/tb_vga_palette_display.sv
// Scoreboard bench for vga_palette_display: directed pixels push hand-computed
// expectations tagged with their due cycle; a monitor pops and compares.
module tb_vga_palette_display;

    logic       clk_25 = 1'b0;
    logic       rst_n;
    logic [9:0] h_count, v_count;
    logic       bright;
    logic [1:0] data, mode;
    logic       pal_we;
    logic [1:0] pal_addr;
    logic [2:0] pal_wdata;
    logic [2:0] rgb;
    logic       rgb_valid;

    typedef struct {
        int         due;
        logic [2:0] rgb;
        logic       v;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_fail  = 0;

    vga_palette_display dut (
        .clk_25   (clk_25),
        .rst_n    (rst_n),
        .h_count  (h_count),
        .v_count  (v_count),
        .bright   (bright),
        .data     (data),
        .mode     (mode),
        .pal_we   (pal_we),
        .pal_addr (pal_addr),
        .pal_wdata(pal_wdata),
        .rgb      (rgb),
        .rgb_valid(rgb_valid)
    );

    always #20 clk_25 = ~clk_25;

    always @(posedge clk_25) cyc <= cyc + 1;

    // Monitor: compare every expectation that falls due this cycle.
    always @(negedge clk_25) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_check++;
            if (e.due != cyc || rgb !== e.rgb || rgb_valid !== e.v) begin
                n_fail++;
                $display("FAIL %s: cycle %0d rgb=%b valid=%b, required rgb=%b valid=%b (due %0d)",
                         e.name, cyc, rgb, rgb_valid, e.rgb, e.v, e.due);
            end
        end
    end

    task automatic drive(input logic rst, input logic [9:0] h, input logic [9:0] v,
                         input logic b, input logic [1:0] d, input logic [1:0] m,
                         input logic we, input logic [1:0] pa, input logic [2:0] pd,
                         input logic [2:0] er, input logic ev, input string name);
        exp_t e;
        @(negedge clk_25);
        rst_n     = rst;
        h_count   = h;
        v_count   = v;
        bright    = b;
        data      = d;
        mode      = m;
        pal_we    = we;
        pal_addr  = pa;
        pal_wdata = pd;
        e.due  = cyc + 2;
        e.rgb  = er;
        e.v    = ev;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic px(input logic [9:0] h, input logic [9:0] v, input logic b,
                      input logic [1:0] d, input logic [1:0] m,
                      input logic [2:0] er, input logic ev, input string name);
        drive(1'b1, h, v, b, d, m, 1'b0, 2'd0, 3'd0, er, ev, name);
    endtask

    initial begin
        rst_n = 1'b0; h_count = 10'd300; v_count = 10'd300; bright = 1'b0;
        data = 2'd0; mode = 2'd0; pal_we = 1'b0; pal_addr = 2'd0; pal_wdata = 3'd0;

        drive(1'b0, 10'd300, 10'd300, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0, 3'b000, 1'b0, "reset0");
        drive(1'b0, 10'd300, 10'd300, 1'b1, 2'd0, 2'd0, 1'b0, 2'd0, 3'd0, 3'b000, 1'b0, "reset1");

        // Default palette in mode 00
        px(10'd300, 10'd300, 1'b1, 2'd0, 2'b00, 3'b111, 1'b1, "pal0");
        px(10'd300, 10'd300, 1'b1, 2'd1, 2'b00, 3'b011, 1'b1, "pal1");
        px(10'd300, 10'd300, 1'b1, 2'd2, 2'b00, 3'b101, 1'b1, "pal2");
        px(10'd300, 10'd300, 1'b1, 2'd3, 2'b00, 3'b001, 1'b1, "pal3");

        // Blanking in every mode
        px(10'd300, 10'd300, 1'b0, 2'd1, 2'b00, 3'b000, 1'b0, "blank_m0");
        px(10'd165, 10'd200, 1'b0, 2'd1, 2'b01, 3'b000, 1'b0, "blank_m1");
        px(10'h3FF, 10'd200, 1'b0, 2'd1, 2'b10, 3'b000, 1'b0, "blank_m2");
        px(10'd400, 10'd200, 1'b0, 2'd0, 2'b11, 3'b000, 1'b0, "blank_m3");

        // Write to entry 2 while it is being looked up
        px(10'd300, 10'd300, 1'b1, 2'd2, 2'b00, 3'b101, 1'b1, "wr_old");
        drive(1'b1, 10'd300, 10'd300, 1'b1, 2'd2, 2'b00, 1'b1, 2'd2, 3'b010, 3'b010, 1'b1, "wr_cyc");
        px(10'd300, 10'd300, 1'b1, 2'd2, 2'b00, 3'b010, 1'b1, "wr_new");
        px(10'd300, 10'd300, 1'b1, 2'd3, 2'b00, 3'b001, 1'b1, "wr_other");

        // Write accepted during blanking in mode 10
        drive(1'b1, 10'd300, 10'd300, 1'b0, 2'd0, 2'b10, 1'b1, 2'd3, 3'b110, 3'b000, 1'b0, "wr_blank");
        px(10'd300, 10'd300, 1'b1, 2'd3, 2'b00, 3'b110, 1'b1, "wr_blank_rd");

        // Mode 01 border edges
        px(10'd165, 10'd200, 1'b1, 2'd0, 2'b01, 3'b111, 1'b1, "bd_h165_d0");
        px(10'd400, 10'd200, 1'b1, 2'd0, 2'b01, 3'b111, 1'b1, "bd_h400_d0");
        px(10'd165, 10'd200, 1'b1, 2'd1, 2'b01, 3'b111, 1'b1, "bd_h165");
        px(10'd400, 10'd200, 1'b1, 2'd1, 2'b01, 3'b011, 1'b1, "bd_h400");
        px(10'd160, 10'd200, 1'b1, 2'd1, 2'b01, 3'b111, 1'b1, "bd_h160");
        px(10'd159, 10'd200, 1'b1, 2'd1, 2'b01, 3'b011, 1'b1, "bd_h159");
        px(10'd169, 10'd200, 1'b1, 2'd1, 2'b01, 3'b111, 1'b1, "bd_h169");
        px(10'd170, 10'd200, 1'b1, 2'd1, 2'b01, 3'b011, 1'b1, "bd_h170");
        px(10'd789, 10'd200, 1'b1, 2'd1, 2'b01, 3'b011, 1'b1, "bd_h789");
        px(10'd790, 10'd200, 1'b1, 2'd1, 2'b01, 3'b111, 1'b1, "bd_h790");
        px(10'd799, 10'd200, 1'b1, 2'd1, 2'b01, 3'b111, 1'b1, "bd_h799");
        px(10'd800, 10'd200, 1'b1, 2'd1, 2'b01, 3'b011, 1'b1, "bd_h800");
        px(10'd400, 10'd40,  1'b1, 2'd1, 2'b01, 3'b011, 1'b1, "bd_v40");
        px(10'd400, 10'd41,  1'b1, 2'd1, 2'b01, 3'b111, 1'b1, "bd_v41");
        px(10'd400, 10'd50,  1'b1, 2'd1, 2'b01, 3'b111, 1'b1, "bd_v50");
        px(10'd400, 10'd51,  1'b1, 2'd1, 2'b01, 3'b011, 1'b1, "bd_v51");
        px(10'd400, 10'd510, 1'b1, 2'd1, 2'b01, 3'b011, 1'b1, "bd_v510");
        px(10'd400, 10'd511, 1'b1, 2'd1, 2'b01, 3'b111, 1'b1, "bd_v511");
        px(10'd400, 10'd520, 1'b1, 2'd1, 2'b01, 3'b111, 1'b1, "bd_v520");
        px(10'd400, 10'd521, 1'b1, 2'd1, 2'b01, 3'b011, 1'b1, "bd_v521");

        // Colour bars, with a mode switch on consecutive pixels
        px(10'h180, 10'd200, 1'b1, 2'd1, 2'b10, 3'b011, 1'b1, "bar_180");
        px(10'h3FF, 10'd200, 1'b1, 2'd0, 2'b10, 3'b111, 1'b1, "bar_3ff");
        px(10'h07F, 10'd200, 1'b1, 2'd3, 2'b10, 3'b000, 1'b1, "bar_07f");
        px(10'h280, 10'd200, 1'b1, 2'd2, 2'b10, 3'b101, 1'b1, "bar_280");
        px(10'h280, 10'd200, 1'b1, 2'd1, 2'b00, 3'b011, 1'b1, "mode_sw");

        // Blink: frame 0 not inverted, frame 32 inverted, frame 64 (wrapped) not
        px(10'd400, 10'd200, 1'b1, 2'd0, 2'b11, 3'b111, 1'b1, "blink_f0");
        for (int i = 0; i < 32; i++) begin
            px(10'd0, 10'd0, 1'b0, 2'd0, 2'b11, 3'b000, 1'b0, "frame_start");
        end
        px(10'd400, 10'd200, 1'b1, 2'd0, 2'b11, 3'b000, 1'b1, "blink_f32_d0");
        px(10'd400, 10'd200, 1'b1, 2'd1, 2'b11, 3'b100, 1'b1, "blink_f32_d1");
        px(10'd400, 10'd200, 1'b1, 2'd2, 2'b11, 3'b101, 1'b1, "blink_f32_d2");
        px(10'd400, 10'd200, 1'b1, 2'd0, 2'b00, 3'b111, 1'b1, "blink_m0");
        for (int i = 0; i < 32; i++) begin
            px(10'd0, 10'd0, 1'b0, 2'd0, 2'b11, 3'b000, 1'b0, "frame_start");
        end
        px(10'd400, 10'd200, 1'b1, 2'd0, 2'b11, 3'b111, 1'b1, "blink_f64");

        // Mid-line reset with a colliding palette write
        px(10'd300, 10'd300, 1'b1, 2'd3, 2'b00, 3'b110, 1'b1, "pre_rst");
        px(10'd301, 10'd300, 1'b1, 2'd2, 2'b00, 3'b000, 1'b0, "rst_flush0");
        drive(1'b0, 10'd302, 10'd300, 1'b1, 2'd2, 2'b00, 1'b1, 2'd1, 3'b000, 3'b000, 1'b0, "rst_flush1");
        px(10'd303, 10'd300, 1'b1, 2'd2, 2'b00, 3'b101, 1'b1, "rst_pal2");
        px(10'd304, 10'd300, 1'b1, 2'd3, 2'b00, 3'b001, 1'b1, "rst_pal3");
        px(10'd305, 10'd300, 1'b1, 2'd1, 2'b00, 3'b011, 1'b1, "rst_pal1");
        px(10'd306, 10'd300, 1'b1, 2'd0, 2'b00, 3'b111, 1'b1, "rst_pal0");

        repeat (4) @(negedge clk_25);
        #1;
        n_check++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_palette_display.md
VGA_PALETTE_DISPLAY -- requirements
Module: vga_palette_display

Interface
- REQ-001: Parameter DATA_W, default 2: pixel code width; palette depth is 2^DATA_W entries.
- REQ-002: Parameter RGB_W, default 3: colour output width; legal range is RGB_W >= 3.
- REQ-003: Parameter BORDER, default 10: border thickness in pixels/lines for mode 01.
- REQ-004: Parameters H_START 160, H_END 799, V_START 41, V_END 520: active window limits, all inclusive.
- REQ-005: Parameter BORDER_COLOR, default all-ones on bits [2:0] and 0 elsewhere: colour drawn in the border.
- REQ-006: Parameter BLINK_BIT, default 5: frame-counter bit that drives blink in mode 11.
- REQ-007: clk_25  in  1  pixel clock; the block has one clock.
- REQ-008: rst_n  in  1  synchronous, active-low reset.
- REQ-009: h_count  in  10  horizontal pixel counter.
- REQ-010: v_count  in  10  vertical line counter.
- REQ-011: bright  in  1  active-video flag.
- REQ-012: data  in  DATA_W  pixel code.
- REQ-013: mode  in  2  display mode: 00 palette, 01 palette+border, 10 colour bars, 11 palette+blink.
- REQ-014: pal_we  in  1  palette write strobe.
- REQ-015: pal_addr  in  DATA_W  palette write index.
- REQ-016: pal_wdata  in  RGB_W  palette write colour.
- REQ-017: rgb  out  RGB_W  registered pixel colour.
- REQ-018: rgb_valid  out  1  bright delayed to align with rgb.

Function
- REQ-019: Latency from inputs h_count/v_count/bright/data/mode to rgb/rgb_valid SHALL be exactly 2 clk_25 cycles, fully pipelined, one pixel per cycle.
- REQ-020: Stage 1 SHALL register data, bright, mode, a border flag, a bar index (h_count[9:7]) and the frame counter's blink bit.
- REQ-021: Stage 2 SHALL register rgb and rgb_valid.
- REQ-022: Border flag SHALL be 1 when h_count in [H_START, H_START+BORDER-1] or [H_END-BORDER+1, H_END], or v_count in [V_START, V_START+BORDER-1] or [V_END-BORDER+1, V_END].
- REQ-023: If the stage-1 bright bit is 0, rgb SHALL be 0 in every mode.
- REQ-024: Mode 00: rgb SHALL be palette[data].
- REQ-025: Mode 01: rgb SHALL be BORDER_COLOR when the border flag is set, else palette[data].
- REQ-026: Mode 10: rgb SHALL be the bar index zero-extended to RGB_W; data is ignored.
- REQ-027: Mode 11: rgb SHALL be ~palette[data] when the blink bit is 1, else palette[data].
- REQ-028: Palette SHALL be a register array of 2^DATA_W x RGB_W bits.
- REQ-029: When pal_we=1 at a clock edge, the palette SHALL write pal_wdata into palette[pal_addr] at that edge.
- REQ-030: A stage-2 lookup of the same entry in the same cycle as a write SHALL return the old value; the new value is visible from the next cycle.
- REQ-031: Palette writes SHALL be accepted regardless of bright and mode.
- REQ-032: Frame counter (6 bits) SHALL increment when h_count==0 and v_count==0.
- REQ-033: The frame counter SHALL wrap 63->0.
- REQ-034: A mode change SHALL take effect on the pixel sampled in the same cycle, appearing on rgb 2 cycles later; no glitch between pipeline stages.

Reset
- REQ-035: While rst_n=0 at a clock edge, rgb, rgb_valid, all pipeline registers and the frame counter SHALL clear to 0.
- REQ-036: While rst_n=0 at a clock edge, palette entries 0..3 SHALL load 111, 011, 101, 001 in bits [2:0] (upper bits 0), and all other entries SHALL load 0.
- REQ-037: Reset asserted mid-frame SHALL discard in-flight pixels; the output is valid again 2 cycles after rst_n returns high.
- REQ-038: When reset and pal_we are asserted together, reset SHALL win.

Verification
- REQ-039: Reset, mode 00, bright=1, data 00/01/10/11 on consecutive cycles -> rgb 111/011/101/001 starting 2 cycles later, rgb_valid=1.
- REQ-040: pal_we with pal_addr=2, pal_wdata=010 while data=2 streams -> old 101 for the write-cycle lookup, then 010.
- REQ-041: Mode 01, h_count=165, v_count=200, data=0 -> rgb=111 (BORDER_COLOR); h_count=400 -> rgb=palette[0].
- REQ-042: Mode 10, h_count=0x180 -> rgb=011; bright=0 in any mode -> rgb=000, rgb_valid=0.
- REQ-043: Mode 11, 32 frame starts (h=v=0) -> rgb inverted (palette[0]=111 gives 000); rgb not inverted after 64 frame starts.
- REQ-044: rst_n low for 1 cycle mid-line after palette writes -> rgb=0 for 2 cycles, palette back to default values.
